led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 16 +
 rtl/led_seq_tick.sv | 38 +++
 rtl/led_sequencer.sv | 147 ++++++++++++++
 tb/tb_led_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings and default
// parameter values. Optional PWM dimming is enabled with LED_SEQUENCER_PWM_EN.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    FILL   = 2'b11
  } mode_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SEG_LEN = 3;
  localparam int DEF_DIV     = 1048577;

endpackage

// File: rtl/led_seq_tick.sv
// Free-running prescaler: counts 0..DIV-1 and raises tick for exactly the
// cycle in which the count sits at DIV-1. Unaffected by start/clear.
module led_seq_tick
  import led_seq_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  // Next count wraps at DIV-1; tick is registered alongside the count it flags
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    tick_d  = (count_d == LAST);
  end

  // Prescaler state, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate left/right, bounce and fill patterns that
// advance one step per prescaler tick while start is high.
// Optional feature: define LED_SEQUENCER_PWM_EN to add a duty input that
// dims the LEDs with a 16-step free-running PWM.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SEG_LEN = DEF_SEG_LEN,
  parameter int DIV     = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [1:0]       mode,
`ifdef LED_SEQUENCER_PWM_EN
  input  logic [3:0]       duty,
`endif
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             dir
);

  localparam int               KW       = $clog2(WIDTH + 1);
  localparam logic [KW-1:0]    K_LAST   = KW'(WIDTH);
  localparam logic [WIDTH-1:0] SEG_INIT = {WIDTH{1'b1}} >> (WIDTH - SEG_LEN);

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic [KW-1:0]    k_q, k_d;
  logic             tick_w;

  // Pattern a mode starts from after reset, a mode change or clear
  function automatic logic [WIDTH-1:0] init_pat(input mode_e m);
    return (m == FILL) ? '0 : SEG_INIT;
  endfunction

  // Fill pattern for step k: the k lowest bits lit
  function automatic logic [WIDTH-1:0] fill_pat(input logic [KW-1:0] k);
    logic [WIDTH-1:0] f;
    for (int i = 0; i < WIDTH; i++) begin
      f[i] = (i < int'(k));
    end
    return f;
  endfunction

  led_seq_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_w)
  );

  // Next-state: clear and mode change both reload the initial pattern and
  // outrank a step; a step uses the registered mode.
  always_comb begin
    mode_d = mode_e'(mode);
    pat_d  = pat_q;
    dir_d  = dir_q;
    k_d    = k_q;
    if (clear || (mode_d != mode_q)) begin
      pat_d = init_pat(mode_d);
      dir_d = 1'b1;
      k_d   = '0;
    end else if (tick_w && start) begin
      unique case (mode_q)
        ROT_L: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        ROT_R: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
        BOUNCE: begin
          if (dir_q) begin
            if (pat_q[WIDTH-1]) begin
              pat_d = pat_q >> 1;
              dir_d = 1'b0;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = 1'b1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        FILL: begin
          if (k_q == K_LAST) begin
            k_d   = '0;
            pat_d = '0;
          end else begin
            k_d   = k_q + KW'(1);
            pat_d = fill_pat(k_q + KW'(1));
          end
        end
        default: pat_d = pat_q;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= ROT_L;
      pat_q  <= SEG_INIT;
      dir_q  <= 1'b1;
      k_q    <= '0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      k_q    <= k_d;
    end
  end

`ifdef LED_SEQUENCER_PWM_EN
  logic [3:0] p_q, p_d;

  // PWM phase counter advances every clock
  always_comb begin
    p_d = p_q + 4'd1;
  end

  // PWM phase register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q <= 4'd0;
    end else begin
      p_q <= p_d;
    end
  end

  // LEDs lit only during the first duty phases of each 16-clock window
  always_comb begin
    led = (p_q < duty) ? pat_q : '0;
  end
`else
  // LEDs follow the pattern directly
  always_comb begin
    led = pat_q;
  end
`endif

  assign tick = tick_w;
  assign dir  = dir_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at WIDTH=8, SEG_LEN=3, DIV=4.
// Define LED_SEQUENCER_PWM_EN to exercise the dimming variant.
module tb_led_sequencer;

  localparam int DIV_TB = 4;

  localparam logic [7:0] BOUNCE_SEQ [0:10] =
    '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E};
  localparam logic       BOUNCE_DIR [0:10] =
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] ROTL_SEQ [0:7] =
    '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};
  localparam logic [7:0] ROTR_SEQ [0:3] =
    '{8'h83, 8'hC1, 8'hE0, 8'h70};
  localparam logic [7:0] FILL_SEQ [0:9] =
    '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

  logic       clk;
  logic       reset;
  logic       start;
  logic       clear;
  logic [1:0] mode;
  logic [7:0] led;
  logic       tick;
  logic       dir;
`ifdef LED_SEQUENCER_PWM_EN
  logic [3:0] duty;
`endif

  int checks = 0;
  int errors = 0;

  led_sequencer #(.WIDTH(8), .SEG_LEN(3), .DIV(DIV_TB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .clear (clear),
    .mode  (mode),
`ifdef LED_SEQUENCER_PWM_EN
    .duty  (duty),
`endif
    .led   (led),
    .tick  (tick),
    .dir   (dir)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Waits on falling edges until tick is seen high; n = edges waited
  task automatic wait_tick(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 3 * DIV_TB && !ok; i++) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; clear = 1'b0; mode = 2'b10;
`ifdef LED_SEQUENCER_PWM_EN
    duty = 4'd15;
`endif
    #2 reset = 1'b0;
    #1;
    checks++;
    if (led !== 8'h07 || dir !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_async led=%h dir=%b tick=%b want 07/1/0", led, dir, tick);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 8'h07 || dir !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_held led=%h dir=%b tick=%b want 07/1/0", led, dir, tick);
    end
    reset = 1'b1;
  endtask

  task automatic test_bounce;
    bit ok;
    int n;
    for (int i = 0; i < 11; i++) begin
      wait_tick(ok, n);
      checks++;
      if (!ok || n != 3) begin
        errors++;
        $display("FAIL bounce_tick_gap step=%0d ok=%0b gap=%0d want 3", i, ok, n);
      end
      @(negedge clk);
      checks++;
      if (led !== BOUNCE_SEQ[i] || dir !== BOUNCE_DIR[i]) begin
        errors++;
        $display("FAIL bounce_step %0d led=%h dir=%b want %h/%b",
                 i, led, dir, BOUNCE_SEQ[i], BOUNCE_DIR[i]);
      end
    end
  endtask

  task automatic test_rot_l;
    bit ok;
    int n;
    mode = 2'b00;
    @(negedge clk);
    checks++;
    if (led !== 8'h07) begin
      errors++;
      $display("FAIL rotl_load led=%h want 07", led);
    end
    for (int i = 0; i < 8; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
      checks++;
      if (!ok || led !== ROTL_SEQ[i]) begin
        errors++;
        $display("FAIL rotl_step %0d ok=%0b led=%h want %h", i, ok, led, ROTL_SEQ[i]);
      end
    end
  endtask

  task automatic test_rot_r;
    bit ok;
    int n;
    mode = 2'b01;
    @(negedge clk);
    checks++;
    if (led !== 8'h07) begin
      errors++;
      $display("FAIL rotr_load led=%h want 07", led);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
      checks++;
      if (!ok || led !== ROTR_SEQ[i]) begin
        errors++;
        $display("FAIL rotr_step %0d ok=%0b led=%h want %h", i, ok, led, ROTR_SEQ[i]);
      end
    end
  endtask

  task automatic test_fill;
    bit ok;
    int n;
    mode = 2'b11;
    @(negedge clk);
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL fill_load led=%h want 00", led);
    end
    for (int i = 0; i < 10; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
      checks++;
      if (!ok || led !== FILL_SEQ[i]) begin
        errors++;
        $display("FAIL fill_step %0d ok=%0b led=%h want %h", i, ok, led, FILL_SEQ[i]);
      end
    end
  endtask

  task automatic test_clear_mode;
    bit ok;
    int n;
    mode = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
    end
    checks++;
    if (led !== 8'h70 || dir !== 1'b0) begin
      errors++;
      $display("FAIL clear_setup led=%h dir=%b want 70/0", led, dir);
    end
    // Tick is high now: clear and mode change land on the stepping edge
    wait_tick(ok, n);
    clear = 1'b1;
    mode  = 2'b01;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (!ok || led !== 8'h07 || dir !== 1'b1) begin
      errors++;
      $display("FAIL clear_mode_tick ok=%0b led=%h dir=%b want 07/1", ok, led, dir);
    end
    wait_tick(ok, n);
    checks++;
    if (!ok || n != 3) begin
      errors++;
      $display("FAIL clear_prescaler ok=%0b gap=%0d want 3", ok, n);
    end
    @(negedge clk);
    checks++;
    if (led !== 8'h83) begin
      errors++;
      $display("FAIL clear_resume_rotr led=%h want 83", led);
    end
    // Clear alone in FILL must also restart k
    mode = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL clear_fill led=%h want 00", led);
    end
    wait_tick(ok, n);
    @(negedge clk);
    checks++;
    if (!ok || led !== 8'h01) begin
      errors++;
      $display("FAIL clear_fill_k ok=%0b led=%h want 01", ok, led);
    end
  endtask

  task automatic test_hold;
    bit ok;
    int n;
    int held_ticks;
    mode = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
    end
    start = 1'b0;
    held_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      wait_tick(ok, n);
      if (ok) held_ticks++;
      @(negedge clk);
      checks++;
      if (led !== 8'h38) begin
        errors++;
        $display("FAIL hold_led tick=%0d led=%h want 38", i, led);
      end
    end
    checks++;
    if (held_ticks != 10 || dir !== 1'b1) begin
      errors++;
      $display("FAIL hold_ticks ticks=%0d dir=%b want 10/1", held_ticks, dir);
    end
    start = 1'b1;
    wait_tick(ok, n);
    @(negedge clk);
    checks++;
    if (!ok || led !== 8'h70) begin
      errors++;
      $display("FAIL hold_resume ok=%0b led=%h want 70", ok, led);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    mode = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      wait_tick(ok, n);
      @(negedge clk);
    end
    checks++;
    if (led !== 8'h1C) begin
      errors++;
      $display("FAIL midreset_setup led=%h want 1C", led);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (led !== 8'h07 || dir !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async led=%h dir=%b tick=%b want 07/1/0", led, dir, tick);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_tick(ok, n);
    checks++;
    if (!ok || n != 3) begin
      errors++;
      $display("FAIL midreset_first_tick ok=%0b gap=%0d want 3", ok, n);
    end
    @(negedge clk);
    checks++;
    if (led !== 8'h0E) begin
      errors++;
      $display("FAIL midreset_step led=%h want 0E", led);
    end
  endtask

`ifdef LED_SEQUENCER_PWM_EN
  task automatic test_pwm;
    int         cyc;
    logic [7:0] exp_led;
    start = 1'b0; clear = 1'b0; mode = 2'b00; duty = 4'd4;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cyc++;
      exp_led = ((cyc % 16) < 4) ? 8'h07 : 8'h00;
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL pwm_duty4 cyc=%0d led=%h want %h", cyc, led, exp_led);
      end
    end
    duty = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (led !== 8'h00) begin
        errors++;
        $display("FAIL pwm_duty0 cyc=%0d led=%h want 00", cyc, led);
      end
    end
    duty = 4'd15;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cyc++;
      exp_led = ((cyc % 16) < 15) ? 8'h07 : 8'h00;
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL pwm_duty15 cyc=%0d led=%h want %h", cyc, led, exp_led);
      end
    end
  endtask
`endif

  // Test sequence and report
  initial begin
    test_reset;
`ifdef LED_SEQUENCER_PWM_EN
    test_pwm;
`else
    test_bounce;
    test_rot_l;
    test_rot_r;
    test_fill;
    test_clear_mode;
    test_hold;
    test_reset_mid;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
